// File: rtl/stream_pkg.sv
// Shared types and default widths for the stream width converters.
package stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int IN_W_DEF  = 32;
  localparam int OUT_W_DEF = 8;

endpackage

// File: rtl/stream_downsizer.sv
// Splits each IN_W-bit input word into RATIO OUT_W-bit beats, emitted LSB first,
// with a zero-bubble reload when the final beat and the next word meet.
module stream_downsizer
  import stream_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic             m_last
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CW    = $clog2(RATIO);
  localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

  if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_bad_widths
    $error("stream_downsizer: IN_W must be a multiple of OUT_W with RATIO >= 2");
  end

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IN_W-1:0]   shift_q, shift_d;
  logic              is_last;

  assign is_last = (state_q == SEND) && (cnt_q == LAST_CNT);

  // m_valid comes straight from the state flop, never from m_ready/s_valid.
  assign m_valid = (state_q == SEND);
  assign m_data  = (state_q == SEND) ? shift_q[OUT_W-1:0] : '0;
  assign m_last  = is_last;
  assign s_ready = (state_q == IDLE) || (m_ready && is_last);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          shift_d = s_data;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (is_last) begin
            if (s_valid) begin
              shift_d = s_data;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_d = shift_q >> OUT_W;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: tb/tb_stream_downsizer.sv
// Directed and randomized checks for the 32-to-8 stream downsizer.
module tb_stream_downsizer;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        m_last;

  int checks = 0;
  int errors = 0;

  stream_downsizer #(.IN_W(32), .OUT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m_valid, m_last, m_data} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h want 0 0 00", m_valid, m_last, m_data);
    end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_ready, m_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got s_ready=%b m_valid=%b want 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    cyc();
    s_valid = 1'b1; s_data = 32'hDDCCBBAA; m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_ready, m_valid} !== 2'b10) begin
      errors++;
      $display("FAIL single_accept: got s_ready=%b m_valid=%b want 1 0", s_ready, m_valid);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      s_valid = 1'b0; s_data = 32'h5A5A5A5A;
      @(negedge clk);
      checks++;
      if ({m_valid, m_last, m_data} !== {1'b1, k == 3, exp_b[k]}) begin
        errors++;
        $display("FAIL single_beat%0d: got v=%b l=%b d=%h want 1 %b %h",
                 k, m_valid, m_last, m_data, k == 3, exp_b[k]);
      end
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({m_valid, s_ready} !== 2'b01) begin
      errors++;
      $display("FAIL single_idle: got m_valid=%b s_ready=%b want 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic last;
    cyc();
    s_valid = 1'b1; s_data = 32'h03020100; m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      s_valid = (k <= 3); s_data = 32'h07060504;
      last = (k == 3) || (k == 7);
      @(negedge clk);
      checks++;
      if ({m_valid, m_last, m_data, s_ready} !== {1'b1, last, 8'(k), last}) begin
        errors++;
        $display("FAIL b2b_beat%0d: got v=%b l=%b d=%h sr=%b want 1 %b %h %b",
                 k, m_valid, m_last, m_data, s_ready, last, 8'(k), last);
      end
    end
    cyc();
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got m_valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [7] = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33, 8'h44};
    logic       rdy   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    cyc();
    s_valid = 1'b1; s_data = 32'h44332211; m_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      cyc();
      // A junk word is offered while the current word is still draining.
      s_valid = (k < 6); s_data = 32'hDEADBEEF; m_ready = rdy[k];
      @(negedge clk);
      checks++;
      if ({m_valid, m_last, m_data, s_ready} !== {1'b1, k == 6, exp_d[k], k == 6 && rdy[k]}) begin
        errors++;
        $display("FAIL bp_cycle%0d: got v=%b l=%b d=%h sr=%b want 1 %b %h %b",
                 k, m_valid, m_last, m_data, s_ready, k == 6, exp_d[k], k == 6 && rdy[k]);
      end
    end
    cyc();
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_valid, s_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_no_junk: got m_valid=%b s_ready=%b want 0 1", m_valid, s_ready);
    end
  endtask

  task automatic test_gap();
    cyc();
    s_valid = 1'b1; s_data = 32'h0D0C0B0A; m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      s_valid = 1'b0; s_data = 32'hFFFFFFFF;
      @(negedge clk);
      checks++;
      if ({m_valid, m_data} !== {1'b1, 8'h0A + 8'(k)}) begin
        errors++;
        $display("FAIL gap_w1_beat%0d: got v=%b d=%h want 1 %h", k, m_valid, m_data, 8'h0A + 8'(k));
      end
    end
    for (int g = 0; g < 2; g++) begin
      cyc();
      s_valid = (g == 1); s_data = 32'h1D1C1B1A;
      @(negedge clk);
      checks++;
      if ({m_valid, s_ready} !== 2'b01) begin
        errors++;
        $display("FAIL gap_idle%0d: got m_valid=%b s_ready=%b want 0 1", g, m_valid, s_ready);
      end
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      s_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({m_valid, m_last, m_data} !== {1'b1, k == 3, 8'h1A + 8'(k)}) begin
        errors++;
        $display("FAIL gap_w2_beat%0d: got v=%b l=%b d=%h want 1 %b %h",
                 k, m_valid, m_last, m_data, k == 3, 8'h1A + 8'(k));
      end
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    cyc();
    s_valid = 1'b1; s_data = 32'hA1B2C3D4; m_ready = 1'b1;
    cyc();
    s_valid = 1'b0;
    cyc();
    @(negedge clk);
    checks++;
    if ({m_valid, m_data} !== {1'b1, 8'hC3}) begin
      errors++;
      $display("FAIL rstmid_beat1: got v=%b d=%h want 1 c3", m_valid, m_data);
    end
    cyc();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_last, m_data} !== 10'b0) begin
      errors++;
      $display("FAIL rstmid_async: got v=%b l=%b d=%h want 0 0 00", m_valid, m_last, m_data);
    end
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({m_valid, s_ready} !== 2'b01) begin
        errors++;
        $display("FAIL rstmid_after%0d: got m_valid=%b s_ready=%b d=%h want 0 1", k, m_valid, s_ready, m_data);
      end
      cyc();
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_q [$];
    logic [31:0] cur;
    logic [31:0] asm;
    logic [31:0] exp_w;
    bit          have = 0;
    int          sent = 0;
    int          got = 0;
    int          beat = 0;
    int          cycles = 0;
    asm = '0;
    while (got < 1000 && cycles < 40000) begin
      cyc();
      cycles++;
      if (!have && sent < 1000) begin
        cur  = $urandom;
        have = 1;
      end
      s_valid = have && ($urandom_range(0, 1) == 1);
      s_data  = s_valid ? cur : $urandom;
      m_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (s_valid && s_ready) begin
        exp_q.push_back(cur);
        have = 0;
        sent++;
      end
      if (m_valid && m_ready) begin
        asm[beat*8 +: 8] = m_data;
        if (beat == 3) begin
          exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
          checks++;
          if (asm !== exp_w || m_last !== 1'b1) begin
            errors++;
            $display("FAIL rand_word%0d: got %h last=%b want %h last=1", got, asm, m_last, exp_w);
          end
          got++;
          beat = 0;
        end else begin
          checks++;
          if (m_last !== 1'b0) begin
            errors++;
            $display("FAIL rand_last_early: word %0d beat %0d got m_last=%b want 0", got, beat, m_last);
          end
          beat++;
        end
      end
    end
    checks++;
    if (got != 1000) begin
      errors++;
      $display("FAIL rand_count: got %0d words want 1000 (cycles %0d)", got, cycles);
    end
    cyc();
    s_valid = 1'b0; m_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_gap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_downsizer.md
STREAM_DOWNSIZER -- requirements
Module: stream_downsizer

Interface
REQ-001 Parameter IN_W, default 32, input word width in bits.
REQ-002 Parameter OUT_W, default 8, output beat width in bits.
REQ-003 Derived constant RATIO = IN_W/OUT_W, the number of beats per word; CW = $clog2(RATIO), the beat counter width.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_valid  input  1  upstream word valid; fed by the pipeline-register stage out_valid.
REQ-007 s_ready  output  1  downsizer can accept a word this cycle.
REQ-008 s_data  input  IN_W  upstream word.
REQ-009 m_valid  output  1  output beat valid.
REQ-010 m_ready  input  1  downstream accepts a beat.
REQ-011 m_data  output  OUT_W  current output beat.
REQ-012 m_last  output  1  current beat is the final beat of its word.

Function
REQ-013 Handshakes: a word transfers when s_valid && s_ready; a beat transfers when m_valid && m_ready.
REQ-014 FSM states:
- IDLE: no word held.
- SEND: a word is held and its beats are being emitted.
REQ-015 IDLE:
- s_ready = 1, m_valid = 0.
- On a word transfer: load shift register with s_data, cnt = 0, go to SEND.
REQ-016 SEND:
- m_valid = 1.
- m_data = shift register bits [OUT_W-1:0].
- m_last = (cnt == RATIO-1).
REQ-017 Beat order is LSB first: beat k carries s_data[k*OUT_W +: OUT_W].
REQ-018 Non-final beat transfer (cnt < RATIO-1): shift register shifts right by OUT_W and cnt increments.
REQ-019 SEND s_ready = m_ready && (cnt == RATIO-1), as a combinational path.
REQ-020 Final beat transfer with simultaneous word transfer: load the new word, cnt = 0, stay in SEND; zero-bubble, so a steady stream yields m_valid = 1 every cycle.
REQ-021 Final beat transfer without a word transfer: go to IDLE.
REQ-022 Stall (m_valid && !m_ready): m_data, m_last, cnt and the shift register hold; nothing is dropped or duplicated.
REQ-023 Latency: first beat of a word appears on m_data exactly 1 cycle after its word transfer.
REQ-024 A word is never accepted in SEND before its own final beat transfers.
REQ-025 m_valid shall not depend combinationally on m_ready or s_valid.
REQ-026 s_data is ignored whenever s_ready = 0.
REQ-027 Elaboration fails unless IN_W % OUT_W == 0 and RATIO >= 2.

Reset
REQ-028 Reset asserted (async, any state, including mid-word):
- state = IDLE, cnt = 0, shift register = 0.
- m_valid = 0, m_last = 0, m_data = 0.
- s_ready = 1 once reset is released.
REQ-029 A partially emitted word is discarded on reset; no beat of it appears after reset release.
REQ-030 Reset deassertion needs no synchronizer inside this block; clean release is provided at the top level.

Structure
REQ-031 Shared package stream_pkg holds:
- the state enum typedef (IDLE, SEND);
- default width constants IN_W_DEF = 32, OUT_W_DEF = 8.
REQ-032 Single module, no sub-module.
- One always_ff for state, cnt and shift register.
- Combinational assigns for s_ready, m_valid, m_data, m_last.
REQ-033 Fully synthesizable: no latches, no initial blocks, no delays.

Verification
REQ-034 Single word, no stall:
- Stimulus: s_data = 32'hDDCCBBAA, m_ready = 1.
- Response: m_data = AA, BB, CC, DD on 4 consecutive cycles; m_last only on DD; then IDLE with s_ready = 1.
REQ-035 Back-to-back stream:
- Stimulus: words 32'h03020100 and 32'h07060504 offered continuously, m_ready = 1.
- Response: 8 beats 00..07 on 8 consecutive cycles, no bubble; s_ready pulses on the cycles with m_last = 1.
REQ-036 Backpressure:
- Stimulus: m_ready = 0 for 3 cycles during beat 2 of 32'h44332211.
- Response: m_data holds 33 and cnt holds 2 for those 3 cycles; the sequence completes 11, 22, 33, 44 without duplication.
REQ-037 Upstream gap:
- Stimulus: s_valid drops for 2 cycles between two words.
- Response: m_valid = 0 for exactly 2 cycles after the first word's last beat; FSM is in IDLE during the gap.
REQ-038 Reset mid-word:
- Stimulus: assert rst_n = 0 after beat 1 of 32'hA1B2C3D4.
- Response: m_valid, m_last and m_data drop to 0 immediately (async); after release, no C3/B2/A1 beats appear and s_ready = 1.
REQ-039 Random stress with a scoreboard:
- Stimulus: random s_valid/m_ready at 50 % over 1000 words.
- Response: the reassembled output words equal the input words in order.
